// File: rtl/ema_pkg.sv
// Shared types and width helpers for the multi-channel EMA filter.
package ema_pkg;

  typedef enum logic [1:0] {IDLE, MULX, MULY, OUT} state_e;

  // alpha*x and (2^AW-alpha)*y are both WIDTH+AW+1 bits; their sum needs one more.
  function automatic int prod_w(input int w, input int aw);
    return w + aw + 1;
  endfunction

  function automatic int sum_w(input int w, input int aw);
    return w + aw + 2;
  endfunction

  function automatic logic [31:0] alpha_comp(input int aw, input logic [31:0] alpha);
    return (32'd1 << aw) - alpha;
  endfunction

endpackage

// File: rtl/ema_mul.sv
// Registered signed x unsigned multiplier, one cycle latency.
module ema_mul #(
  parameter int A_W = 8,
  parameter int B_W = 9,
  parameter int P_W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [P_W-1:0] p_o
);

  localparam int FW = A_W + B_W + 1;

  logic signed [FW-1:0] a_ext, b_ext, full;
  logic [P_W-1:0]       p_q;

  assign a_ext = FW'($signed(a_i));
  assign b_ext = FW'(b_i);
  assign full  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= P_W'(full);
  end

  assign p_o = p_q;

endmodule

// File: rtl/ema_multi.sv
// Multi-channel EMA: y = (alpha*x + (2^AW-alpha)*y_old) >>> AW per channel,
// one shared multiplier, three cycles per sample.
module ema_multi
  import ema_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AW       = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_ch,
  input  logic [AW-1:0]    in_alpha,
  input  logic             clear_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_ch,
  output logic             busy_o
);

  localparam int PW  = prod_w(WIDTH, AW);
  localparam int SW  = sum_w(WIDTH, AW);
  localparam int AW1 = AW + 1;

  state_e state_q, state_d;

  logic                hs, ch_ok;
  logic [WIDTH-1:0]    x_q, yold_q;
  logic [CW-1:0]       ch_q;
  logic [AW-1:0]       alpha_q;
  logic                init_old_q, chok_q;
  logic [PW-1:0]       px_q, mul_p;
  logic [WIDTH-1:0]    mul_a;
  logic [AW:0]         mul_b, comp;
  logic signed [SW-1:0] sum;
  logic [WIDTH-1:0]    res;
  logic [WIDTH-1:0]    out_data_q;
  logic [CW-1:0]       out_ch_q;
  logic [CHANNELS-1:0] init_q;
  logic [WIDTH-1:0]    ymem_q [CHANNELS];

  assign in_ready = !rst && (state_q == IDLE || (state_q == OUT && out_ready));
  assign hs       = in_valid && in_ready;
  assign ch_ok    = 32'(in_ch) < 32'(CHANNELS);
  assign comp     = AW1'(alpha_comp(AW, 32'(alpha_q)));

  // The multiplier runs one step ahead of the state: alpha*x is launched on the
  // handshake edge (px lands in MULX), (2^AW-alpha)*y_old is launched in MULX
  // and is on the multiplier output throughout MULY, ready to sum on MULY exit.
  assign mul_a = (state_q == MULX) ? yold_q : in_data;
  assign mul_b = (state_q == MULX) ? comp   : {1'b0, in_alpha};

  ema_mul #(.A_W(WIDTH), .B_W(AW1), .P_W(PW)) u_mul (
    .clk (clk),
    .rst (rst),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign sum = SW'($signed(px_q)) + SW'($signed(mul_p));
  assign res = init_old_q ? WIDTH'(sum >>> AW) : x_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = MULX;
      MULX:    state_d = chok_q ? MULY : IDLE;
      MULY:    state_d = OUT;
      OUT:     if (out_ready) state_d = hs ? MULX : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      init_q     <= '0;
      px_q       <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MULX) px_q <= mul_p;
      if (state_q == MULY) begin
        out_data_q     <= res;
        out_ch_q       <= ch_q;
        init_q[ch_q]   <= 1'b1;
      end
      if (clear_i) init_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      x_q        <= in_data;
      ch_q       <= in_ch;
      alpha_q    <= in_alpha;
      chok_q     <= ch_ok;
      yold_q     <= ch_ok ? ymem_q[in_ch] : '0;
      init_old_q <= ch_ok ? init_q[in_ch] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == MULY) ymem_q[ch_q] <= res;
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_ema_multi.sv
// Bench for ema_multi: directed scenarios plus random traffic against an arithmetic model.
module tb_ema_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_ch = '0;
  logic [7:0] in_alpha = '0;
  logic       clear_i = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, busy_o;
  logic [7:0] out_data;
  logic [1:0] out_ch;

  int errors = 0;
  int checks = 0;
  int m_y [4];
  bit m_init [4];

  always #5 clk = ~clk;

  ema_multi #(.WIDTH(8), .AW(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .in_alpha  (in_alpha),
    .clear_i   (clear_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy_o    (busy_o)
  );

  // Reference: first sample loads x, afterwards floor((a*x + (256-a)*y)/256).
  function automatic int model_step(input int ch, input int x, input int a);
    int y;
    if (!m_init[ch]) y = x;
    else             y = (a * x + (256 - a) * m_y[ch]) >>> 8;
    m_y[ch]    = y;
    m_init[ch] = 1'b1;
    return y;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_init[i] = 1'b0;
  endfunction

  // Handshake one sample, wait for its result (out_ready held 1), return after it is consumed.
  // lat counts clock edges from the handshake edge to the first edge showing out_valid.
  task automatic send_and_get(input int ch, input int x, input int a,
                              output int lat, output logic [7:0] d, output logic [1:0] c);
    int n;
    in_ch = 2'(ch); in_data = 8'(x); in_alpha = 8'(a); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : -1;
    d = out_data; c = out_ch;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed_ch0();
    int lat, e;
    logic [7:0] d; logic [1:0] c;
    // init load
    send_and_get(0, 100, 64, lat, d, c); e = model_step(0, 100, 64);
    checks++; if (lat !== 2) begin errors++; $display("FAIL init_latency got=%0d want=2", lat); end
    checks++; if (d !== 8'd100) begin errors++; $display("FAIL init_load got=%0d want=100", $signed(d)); end
    checks++; if (c !== 2'd0) begin errors++; $display("FAIL init_ch got=%0d want=0", c); end
    // alpha=0 holds
    send_and_get(0, -128, 0, lat, d, c); e = model_step(0, -128, 0);
    checks++; if (d !== 8'd100) begin errors++; $display("FAIL hold got=%0d want=100", $signed(d)); end
    // half mix
    send_and_get(0, -100, 128, lat, d, c); e = model_step(0, -100, 128);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL half_mix got=%0d want=0", $signed(d)); end
    // floor of -1/256
    send_and_get(0, -1, 1, lat, d, c); e = model_step(0, -1, 1);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL floor got=%0d want=-1", $signed(d)); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL floor_latency got=%0d want=2", lat); end
  endtask

  task automatic test_back_to_back();
    int q_t [$];
    logic [7:0] q_d [$];
    logic [1:0] q_c [$];
    int stage, lat, e1, e2, a2;
    bit hs;
    logic [7:0] d; logic [1:0] c;
    a2 = $urandom_range(0, 255);
    e1 = model_step(1, 20, 255);
    e2 = model_step(2, -20, a2);
    in_ch = 2'd1; in_data = 8'd20; in_alpha = 8'd255; in_valid = 1'b1;
    stage = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin q_t.push_back(i); q_d.push_back(out_data); q_c.push_back(out_ch); end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (stage == 0) begin in_ch = 2'd2; in_data = 8'(-20); in_alpha = 8'(a2); end
        else in_valid = 1'b0;
        stage++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (q_t.size() != 2) begin
      errors++; $display("FAIL b2b_count got=%0d want=2", q_t.size());
    end else begin
      if (q_c[0] !== 2'd1 || q_d[0] !== 8'(e1)) begin
        errors++; $display("FAIL b2b_first got=(%0d,%0d) want=(1,%0d)", q_c[0], $signed(q_d[0]), e1);
      end
      checks++;
      if (q_c[1] !== 2'd2 || q_d[1] !== 8'(e2)) begin
        errors++; $display("FAIL b2b_second got=(%0d,%0d) want=(2,%0d)", q_c[1], $signed(q_d[1]), e2);
      end
      checks++;
      if (q_t[1] - q_t[0] != 3) begin
        errors++; $display("FAIL b2b_spacing got=%0d want=3", q_t[1] - q_t[0]);
      end
    end
    // channel 0 history untouched by ch1/ch2 traffic
    send_and_get(0, 0, 0, lat, d, c); e1 = model_step(0, 0, 0);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL isolation got=%0d want=-1", $signed(d)); end
  endtask

  task automatic test_backpressure();
    int n, x, a, e;
    logic [7:0] held;
    x = $urandom_range(0, 255); a = $urandom_range(0, 255);
    x = int'($signed(8'(x)));
    e = model_step(3, x, a);
    out_ready = 1'b0;
    in_ch = 2'd3; in_data = 8'(x); in_alpha = 8'(a); in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'd55; in_ch = 2'd0;   // a second offer that must not be taken
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (out_data !== 8'(e)) begin errors++; $display("FAIL bp_data got=%0d want=%0d", $signed(out_data), e); end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || out_ch !== 2'd3 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall cyc=%0d got v=%b d=%0d ch=%0d rdy=%b want v=1 d=%0d ch=3 rdy=0",
                 i, out_valid, $signed(out_data), out_ch, in_ready, $signed(held));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b want=0", out_valid); end
  endtask

  task automatic test_clear();
    int lat, e;
    logic [7:0] d; logic [1:0] c;
    clear_i = 1'b1; @(posedge clk); #1; clear_i = 1'b0;
    model_clear();
    send_and_get(0, 7, 10, lat, d, c); e = model_step(0, 7, 10);
    checks++; if (d !== 8'd7) begin errors++; $display("FAIL clear_reload got=%0d want=7", $signed(d)); end
    send_and_get(1, 50, 3, lat, d, c); e = model_step(1, 50, 3);
    // clear coinciding with the in-flight result: result still out, flag stays cleared
    e = model_step(1, -50, 200);
    in_ch = 2'd1; in_data = 8'(-50); in_alpha = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; clear_i = 1'b1;
    @(posedge clk); #1; clear_i = 1'b0;
    model_clear();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'(e)) begin
      errors++; $display("FAIL clear_inflight got v=%b d=%0d want v=1 d=%0d", out_valid, $signed(out_data), e);
    end
    @(posedge clk); #1;
    send_and_get(1, 33, 1, lat, d, c); e = model_step(1, 33, 1);
    checks++; if (d !== 8'd33) begin errors++; $display("FAIL clear_priority got=%0d want=33", $signed(d)); end
  endtask

  task automatic test_reset_mid();
    int lat, e;
    logic [7:0] d; logic [1:0] c;
    in_ch = 2'd2; in_data = 8'd9; in_alpha = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_mulx got=%b want=1", busy_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid got v=%b busy=%b rdy=%b want 0 0 0", out_valid, busy_o, in_ready);
    end
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_output cyc=%0d got=%b want=0", i, out_valid); end
    end
    send_and_get(2, -9, 5, lat, d, c); e = model_step(2, -9, 5);
    checks++; if (d !== 8'(e)) begin errors++; $display("FAIL rst_reload got=%0d want=%0d", $signed(d), e); end
  endtask

  task automatic test_random();
    int lat, e, ch, x, a;
    logic [7:0] d; logic [1:0] c;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear_i = 1'b1; @(posedge clk); #1; clear_i = 1'b0;
        model_clear();
      end
      ch = $urandom_range(0, 3);
      x  = int'($signed(8'($urandom_range(0, 255))));
      a  = $urandom_range(0, 255);
      send_and_get(ch, x, a, lat, d, c);
      e = model_step(ch, x, a);
      checks++;
      if (d !== 8'(e) || c !== 2'(ch) || lat !== 2) begin
        errors++;
        $display("FAIL random i=%0d got (ch=%0d d=%0d lat=%0d) want (ch=%0d d=%0d lat=2) x=%0d a=%0d",
                 i, c, $signed(d), lat, ch, e, x, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_ch0();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
